inst_fetch_axi: RTL and testbench

INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

---
 rtl/inst_fetch_axi_pkg.sv | 19 +
 rtl/inst_fetch_axi_if.sv | 34 +++
 rtl/inst_fetch_axi.sv | 190 +++++++++++++++++++
 tb/tb_inst_fetch_axi.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_axi_pkg.sv
// Shared constants and FSM encoding for the AXI instruction fetch unit.
// Holds the boot address and the fixed single-beat AXI read attributes.
package inst_fetch_axi_pkg;

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;

    localparam logic [7:0]  ARLEN     = 8'd0;
    localparam logic [2:0]  ARSIZE    = 3'b010;
    localparam logic [1:0]  ARBURST   = 2'b01;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_AR      = 2'd1,
        S_R       = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

endpackage

// File: rtl/inst_fetch_axi_if.sv
// AXI read address/data channels used by the instruction fetch unit.
// The fetch unit is the master; memory or the bench is the slave.
interface inst_fetch_axi_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/inst_fetch_axi.sv
// Single-outstanding AXI instruction fetch with branch delay slot and flush.
// Define FETCH_ADDR_CHECK_EN to trap misaligned fetches (adds fetch_addr_err).
module inst_fetch_axi #(
    parameter logic [31:0] RESET_PC = inst_fetch_axi_pkg::RESET_PC,
    parameter logic [3:0]  FETCH_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_pc_valid,
    input  logic        branch_flag,
    input  logic [31:0] branch_target_address,
    input  logic        flush,
    input  logic [31:0] flush_pc,
`ifdef FETCH_ADDR_CHECK_EN
    output logic        fetch_addr_err,
`endif
    output logic        valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        inst_bus_err,
    inst_fetch_axi_if.master axi
);

    import inst_fetch_axi_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        branch_pending_q, branch_pending_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        drop_q, drop_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        bus_err_q, bus_err_d;
    logic        beat;
    logic        issue;
`ifdef FETCH_ADDR_CHECK_EN
    logic        halt_q, halt_d;
    logic        addr_err_q, addr_err_d;
`endif

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        branch_pending_d = branch_pending_q;
        pending_target_d = pending_target_q;
        drop_d           = drop_q;
        araddr_d         = araddr_q;
        arvalid_d        = arvalid_q;
        rready_d         = rready_q;
        valid_d          = 1'b0;
        if_pc_d          = 32'h0;
        if_inst_d        = 32'h0;
        bus_err_d        = 1'b0;
        issue            = 1'b0;
        beat             = axi.rvalid & axi.rlast;
`ifdef FETCH_ADDR_CHECK_EN
        halt_d           = halt_q & ~flush;
        addr_err_d       = 1'b0;
`endif

        // A redirect always beats a branch resolved in the same cycle.
        if (flush) begin
            pc_d             = flush_pc;
            branch_pending_d = 1'b0;
        end else if (branch_flag) begin
            pending_target_d = branch_target_address;
            branch_pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                issue = next_pc_valid;
`ifdef FETCH_ADDR_CHECK_EN
                if (halt_d) begin
                    issue = 1'b0;
                end else if (next_pc_valid && pc_d[1:0] != 2'b00) begin
                    issue      = 1'b0;
                    valid_d    = 1'b1;
                    if_pc_d    = pc_d;
                    addr_err_d = 1'b1;
                    halt_d     = 1'b1;
                end
`endif
                if (issue) begin
                    state_d   = S_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = pc_d;
                    drop_d    = 1'b0;
                end
            end
            S_AR: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                // araddr stays on its own flop so a flush cannot move it mid-handshake.
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = (flush || drop_q) ? S_DISCARD : S_R;
                end
            end
            S_R: begin
                if (beat) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                    if (!flush) begin
                        valid_d          = 1'b1;
                        if_pc_d          = pc_q;
                        if_inst_d        = axi.rdata;
                        bus_err_d        = axi.rresp != RESP_OKAY;
                        pc_d             = branch_pending_d
                                           ? pending_target_d
                                           : pc_q + 32'd4;
                        branch_pending_d = 1'b0;
                    end
                end else if (flush) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (beat) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            pc_q             <= RESET_PC;
            branch_pending_q <= 1'b0;
            pending_target_q <= 32'h0;
            drop_q           <= 1'b0;
            araddr_q         <= 32'h0;
            arvalid_q        <= 1'b0;
            rready_q         <= 1'b0;
            valid_q          <= 1'b0;
            if_pc_q          <= 32'h0;
            if_inst_q        <= 32'h0;
            bus_err_q        <= 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
            halt_q           <= 1'b0;
            addr_err_q       <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            branch_pending_q <= branch_pending_d;
            pending_target_q <= pending_target_d;
            drop_q           <= drop_d;
            araddr_q         <= araddr_d;
            arvalid_q        <= arvalid_d;
            rready_q         <= rready_d;
            valid_q          <= valid_d;
            if_pc_q          <= if_pc_d;
            if_inst_q        <= if_inst_d;
            bus_err_q        <= bus_err_d;
`ifdef FETCH_ADDR_CHECK_EN
            halt_q           <= halt_d;
            addr_err_q       <= addr_err_d;
`endif
        end
    end

    assign valid        = valid_q;
    assign if_pc        = if_pc_q;
    assign if_inst      = if_inst_q;
    assign inst_bus_err = bus_err_q;
`ifdef FETCH_ADDR_CHECK_EN
    assign fetch_addr_err = addr_err_q;
`endif

    assign axi.arid    = FETCH_ID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = ARLEN;
    assign axi.arsize  = ARSIZE;
    assign axi.arburst = ARBURST;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    logic unused_rid;
    assign unused_rid = ^axi.rid;

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Randomized scoreboard bench for inst_fetch_axi acting as the AXI slave.
// A fetch-level PC model predicts addresses and delivered words.
module tb_inst_fetch_axi;

    logic        clk;
    logic        rst;
    logic        next_pc_valid;
    logic        branch_flag;
    logic [31:0] branch_target_address;
    logic        flush;
    logic [31:0] flush_pc;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        inst_bus_err;
`ifdef FETCH_ADDR_CHECK_EN
    logic        fetch_addr_err;
`endif

    inst_fetch_axi_if axi ();

    inst_fetch_axi dut (
        .clk                   (clk),
        .rst                   (rst),
        .next_pc_valid         (next_pc_valid),
        .branch_flag           (branch_flag),
        .branch_target_address (branch_target_address),
        .flush                 (flush),
        .flush_pc              (flush_pc),
`ifdef FETCH_ADDR_CHECK_EN
        .fetch_addr_err        (fetch_addr_err),
`endif
        .valid                 (valid),
        .if_pc                 (if_pc),
        .if_inst               (if_inst),
        .inst_bus_err          (inst_bus_err),
        .axi                   (axi)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
        logic        aerr;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_pc;
    logic        pend;
    logic [31:0] ptgt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every delivered word must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got pulse pc %h, required none",
                             if_pc);
                end else begin
                    mon_e = sb.pop_front();
                    check("if_pc", if_pc, mon_e.pc);
                    check("if_inst", if_inst, mon_e.inst);
                    check("inst_bus_err", {31'b0, inst_bus_err}, {31'b0, mon_e.err});
`ifdef FETCH_ADDR_CHECK_EN
                    check("fetch_addr_err", {31'b0, fetch_addr_err},
                          {31'b0, mon_e.aerr});
`endif
                end
            end else begin
                check("idle_if_pc", if_pc, 32'h0);
                check("idle_if_inst", if_inst, 32'h0);
            end
        end
    end

    // One fetch as seen by the slave; br_k/fl_k < 0 means no such event.
    task automatic run_txn(input int d_ar, input int d_r,
                           input int br_k, input int fl_k,
                           input logic [31:0] tgt, input logic [31:0] fpc,
                           input logic [31:0] data, input logic [1:0] resp);
        int n;
        bit seen;
        n = d_ar + d_r + 2;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (axi.arvalid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL ar_timeout: got no arvalid, required fetch of %h", exp_pc);
            return;
        end
        for (int k = 0; k < n; k++) begin
            flush                 = (k == fl_k);
            flush_pc              = fpc;
            branch_flag           = (k == br_k);
            branch_target_address = tgt;
            axi.arready           = (k == d_ar);
            axi.rvalid            = (k == n - 1);
            axi.rlast             = 1'b1;
            axi.rdata             = data;
            axi.rresp             = resp;
            if (k <= d_ar) begin
                check("arvalid", {31'b0, axi.arvalid}, 32'd1);
                check("araddr", axi.araddr, exp_pc);
            end
            if (k == d_ar)
                check("ar_consts",
                      {15'b0, axi.arid, axi.arlen, axi.arsize, axi.arburst},
                      {15'b0, 4'h0, 8'h00, 3'b010, 2'b01});
            if (k == d_ar + 1)
                check("arvalid_drop", {31'b0, axi.arvalid}, 32'd0);
            if (k > d_ar)
                check("rready", {31'b0, axi.rready}, 32'd1);
            if (k == n - 1 && fl_k < 0)
                sb.push_back('{pc: exp_pc, inst: data,
                               err: (resp != 2'b00), aerr: 1'b0});
            tick();
        end
        flush       = 1'b0;
        branch_flag = 1'b0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        if (fl_k >= 0) begin
            exp_pc = fpc;
            pend   = 1'b0;
        end else begin
            if (br_k >= 0) begin
                pend = 1'b1;
                ptgt = tgt;
            end
            exp_pc = pend ? ptgt : exp_pc + 32'd4;
            pend   = 1'b0;
        end
    endtask

    // Redirect while idle, with a stale branch that the flush must cancel.
    task automatic idle_flush(input logic [31:0] fpc);
        next_pc_valid = 1'b0;
        tick();
        branch_flag           = 1'b1;
        branch_target_address = 32'h1234_5678;
        tick();
        branch_flag = 1'b0;
        pend        = 1'b1;
        ptgt        = 32'h1234_5678;
        flush       = 1'b1;
        flush_pc    = fpc;
        tick();
        flush = 1'b0;
        exp_pc = fpc;
        pend   = 1'b0;
        tick();
        check("idle_no_ar", {31'b0, axi.arvalid}, 32'd0);
        next_pc_valid = 1'b1;
    endtask

    task automatic rand_txn();
        int d_ar, d_r, n, kind, br_k, fl_k;
        logic [31:0] tgt, fpc, data;
        logic [1:0]  resp;
        d_ar = $urandom_range(0, 3);
        d_r  = $urandom_range(0, 3);
        n    = d_ar + d_r + 2;
        kind = $urandom_range(0, 9);
        br_k = -1;
        fl_k = -1;
        tgt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                            : ($urandom & 32'hFFFF_FFFC);
        fpc  = $urandom & 32'hFFFF_FFFC;
        data = $urandom;
        resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (kind == 6 || kind == 7) br_k = $urandom_range(0, n - 2);
        if (kind >= 8) fl_k = $urandom_range(0, n - 1);
        if (kind == 9) br_k = fl_k;
        run_txn(d_ar, d_r, br_k, fl_k, tgt, fpc, data, resp);
    endtask

    initial begin
        n_checks              = 0;
        n_errors              = 0;
        rst                   = 1'b0;
        next_pc_valid         = 1'b0;
        branch_flag           = 1'b0;
        branch_target_address = 32'h0;
        flush                 = 1'b0;
        flush_pc              = 32'h0;
        axi.arready           = 1'b0;
        axi.rid               = 4'h0;
        axi.rdata             = 32'h0;
        axi.rresp             = 2'b00;
        axi.rlast             = 1'b0;
        axi.rvalid            = 1'b0;
        exp_pc                = 32'hBFC0_0000;
        pend                  = 1'b0;
        ptgt                  = 32'h0;
        tick();
        tick();
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_bus_err", {31'b0, inst_bus_err}, 32'd0);
        check("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
        check("rst_rready", {31'b0, axi.rready}, 32'd0);
        rst = 1'b1;
        tick();
        check("wait_npv", {31'b0, axi.arvalid}, 32'd0);
        next_pc_valid = 1'b1;

        run_txn(0, 0, -1, -1, 32'h0, 32'h0, 32'h2402_0001, 2'b00);
        run_txn(5, 0, -1, -1, 32'h0, 32'h0, $urandom, 2'b00);
        run_txn(0, 1, 1, -1, 32'h8000_0100, 32'h0, $urandom, 2'b00);
        run_txn(0, 2, -1, 2, 32'h0, 32'hBFC0_0380, $urandom, 2'b00);
        run_txn(1, 0, 0, 0, 32'h8000_0200, 32'h0000_1000, $urandom, 2'b00);
        run_txn(0, 0, -1, -1, 32'h0, 32'h0, $urandom, 2'b10);
        run_txn(0, 1, -1, 2, 32'h0, 32'h0000_2000, $urandom, 2'b00);
        run_txn(2, 0, -1, 1, 32'h0, 32'h0000_3000, $urandom, 2'b00);
        idle_flush(32'hFFFF_FFFC);
        run_txn(0, 0, -1, -1, 32'h0, 32'h0, $urandom, 2'b00);
        run_txn(0, 0, -1, -1, 32'h0, 32'h0, $urandom, 2'b00);

`ifdef FETCH_ADDR_CHECK_EN
        next_pc_valid = 1'b0;
        tick();
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0002;
        tick();
        flush = 1'b0;
        sb.push_back('{pc: 32'hBFC0_0002, inst: 32'h0, err: 1'b0, aerr: 1'b1});
        next_pc_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("misaligned_no_ar", {31'b0, axi.arvalid}, 32'd0);
        end
        next_pc_valid = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0010;
        tick();
        flush         = 1'b0;
        exp_pc        = 32'hBFC0_0010;
        next_pc_valid = 1'b1;
        run_txn(0, 0, -1, -1, 32'h0, 32'h0, $urandom, 2'b00);
`endif

        for (int t = 0; t < 250; t++) begin
            rand_txn();
            if (t % 50 == 49) idle_flush($urandom & 32'hFFFF_FFFC);
        end

        // Reset while a beat is owed: nothing may be delivered.
        for (int i = 0; i < 20 && !axi.arvalid; i++) tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_arvalid", {31'b0, axi.arvalid}, 32'd0);
        check("midrst_rready", {31'b0, axi.rready}, 32'd0);
        check("midrst_valid", {31'b0, valid}, 32'd0);
        next_pc_valid = 1'b0;
        axi.rvalid    = 1'b1;
        axi.rlast     = 1'b1;
        axi.rdata     = $urandom;
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        rst        = 1'b1;
        tick();
        check("post_rst_idle", {31'b0, axi.arvalid}, 32'd0);
        exp_pc        = 32'hBFC0_0000;
        pend          = 1'b0;
        next_pc_valid = 1'b1;
        for (int t = 0; t < 20; t++) rand_txn();

        tick();
        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
